mem_arbiter_unit: RTL and testbench
===================================

# mem_arbiter_unit

Arbitrates one single-port unified memory between the core's instruction-fetch port and its load/store port. The block sits between the RV32I top-level memory ports and the external memory. It latches one request at a time and sequences the memory handshake. It generates the stall the core uses to freeze its pipeline. Data accesses have priority, bounded by a fairness counter so fetch cannot starve.

## Interface
Parameters:
- MAX_DM_STREAK, 4: maximum consecutive data grants while fetch is waiting; range 1..15.
- TIMEOUT_CYCLES, 255: memory-wait watchdog limit; 0 disables the watchdog; range 0..255.

Ports:
- clk_in, input, 1: the block's single clock; all state updates on its rising edge.
- rst_in, input, 1: reset; synchronous, active-high.
- if_req_in, input, 1: fetch request; held high until if_ack_out.
- if_addr_in, input, 32: fetch address, held stable while if_req_in is high.
- if_data_out, output, 32: fetched instruction; valid while if_ack_out is high, then holds.
- if_ack_out, output, 1: one-cycle completion pulse for fetch.
- dm_req_in, input, 1: data request; held high until dm_ack_out.
- dm_wr_in, input, 1: 1 = store, 0 = load.
- dm_addr_in, input, 32: data address.
- dm_wdata_in, input, 32: store data.
- dm_wmask_in, input, 4: store byte mask.
- dm_data_out, output, 32: load data; updated on load completion only.
- dm_ack_out, output, 1: one-cycle completion pulse for data.
- mem_req_out, output, 1: memory request; held until mem_ready_in is sampled high.
- mem_wr_out, output, 1: memory write enable.
- mem_addr_out, output, 32: memory address.
- mem_wdata_out, output, 32: memory write data.
- mem_wmask_out, output, 4: byte mask; 4'b0000 for every read.
- mem_data_in, input, 32: memory read data; valid when mem_ready_in is high.
- mem_ready_in, input, 1: memory completion; may be asserted in the first mem_req_out cycle.
- stall_out, output, 1: core pipeline hold.
- err_out, output, 1: pulses together with an ack when that transaction timed out.

## Operation
- The FSM has four states: IDLE, IF_BUSY, DM_BUSY, RESP.
- **IDLE, data grant:** taken if dm_req_in=1 and (if_req_in=0 or streak<MAX_DM_STREAK).
  - Latches dm_wr_in, dm_addr_in, dm_wdata_in and dm_wmask_in into the mem_* output registers.
  - Sets mem_req_out=1 and goes to DM_BUSY.
- **IDLE, fetch grant:** otherwise, if if_req_in=1.
  - Latches if_addr_in, forces mem_wr_out=0 and mem_wmask_out=0.
  - Sets mem_req_out=1 and goes to IF_BUSY.
- **IF_BUSY / DM_BUSY:** mem_* outputs are held stable.
  - When mem_ready_in=1: clear mem_req_out and go to RESP.
  - Read data: mem_data_in is captured into if_data_out (fetch) or dm_data_out (load).
  - Ack: the matching ack asserts for the RESP cycle.
- **RESP:** lasts exactly one cycle and makes no grant, so a request still high in that cycle is not re-granted. Returns to IDLE.
- **Streak counter (4 bits):**
  - A data grant made while if_req_in=1 increments the counter.
  - A data grant with if_req_in=0 clears it.
  - A fetch grant clears it.
- **Watchdog:** an 8-bit counter clears on entry to a BUSY state and increments every BUSY cycle with mem_ready_in=0.
  - When it reaches TIMEOUT_CYCLES and TIMEOUT_CYCLES≠0: clear mem_req_out and go to RESP.
  - That RESP cycle asserts the ack and err_out=1, and drives the captured data to 32'h0.
- stall_out = (if_req_in & ~if_ack_out) | (dm_req_in & ~dm_ack_out); it is combinational.
- A store never modifies dm_data_out.

## Timing
- **Reset:** takes effect on the first clk_in edge with rst_in=1.
  - State goes to IDLE; streak and watchdog counters go to 0.
  - Every output register goes to 0: mem_*, if_data_out, dm_data_out, both acks and err_out.
- **Reset mid-transaction:** the transaction is abandoned.
  - mem_req_out=0 after that edge and no ack is issued.
  - The requester must re-request.
- **Grant:** a request present at edge N drives mem_req_out=1 from edge N onward.
- **Zero-wait memory:** with mem_ready_in=1 in the first request cycle, the ack is high in the cycle after edge N+1.
  - Minimum occupancy is 3 cycles per transaction: IDLE, BUSY, RESP.
- **Wait states:** each memory wait cycle adds one cycle of latency.
- **Simultaneous requests in IDLE:** data wins unless streak==MAX_DM_STREAK.
- **Request drop:** a requester dropping its request while BUSY does not cancel the memory transaction; the ack is still issued.

## Test plan
- **Fetch, zero-wait memory:** if_req, addr 0x0000_0100, mem_ready_in=1 on first mem_req, mem_data_in=0x0000_0013.
  - Expect mem_addr_out=0x100 and mem_wr_out=0.
  - Expect if_ack pulse 2 cycles after the request, with if_data_out=0x13.
  - Expect stall_out high on both of those cycles.
- **Store with 2 wait states:** dm_req, dm_wr=1, addr 0x2004, data 0xDEADBEEF, mask 4'b0011.
  - Expect mem_wmask_out=0011 held for 3 cycles, then a dm_ack pulse.
  - Expect dm_data_out unchanged.
- **Simultaneous requests, MAX_DM_STREAK=4:** if_req held high, dm_req re-asserted each time after its ack.
  - Expect exactly 4 data grants, then 1 fetch grant, then data resumes.
- **Watchdog, TIMEOUT_CYCLES=8:** mem_ready_in held at 0 during a load.
  - Expect mem_req_out to drop after 8 wait cycles.
  - Expect dm_ack=1, err_out=1 and dm_data_out=0 for one cycle.
- **Reset mid-transaction:** assert rst_in during a DM_BUSY wait.
  - Expect all outputs 0 next cycle and no ack.
  - Expect a new fetch afterwards to complete normally.
- **Request held through RESP:** keep if_req high across the RESP cycle.
  - Expect no grant in RESP and a new grant in the following IDLE cycle.

Source files
------------

// File: rtl/mem_arbiter_unit.sv
// ============================================================================
// mem_arbiter_unit
// Single-port memory arbiter between instruction fetch and load/store ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter_unit #(
  parameter int MAX_DM_STREAK  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic [31:0] if_data_out,
  output logic        if_ack_out,
  input  logic        dm_req_in,
  input  logic        dm_wr_in,
  input  logic [31:0] dm_addr_in,
  input  logic [31:0] dm_wdata_in,
  input  logic [3:0]  dm_wmask_in,
  output logic [31:0] dm_data_out,
  output logic        dm_ack_out,
  output logic        mem_req_out,
  output logic        mem_wr_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_wmask_out,
  input  logic [31:0] mem_data_in,
  input  logic        mem_ready_in,
  output logic        stall_out,
  output logic        err_out
);

  localparam logic [3:0] c_MAX_STREAK = 4'(MAX_DM_STREAK);
  localparam logic [8:0] c_TIMEOUT    = 9'(TIMEOUT_CYCLES);
  localparam logic       c_WDOG_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_BUSY = 2'd1,
    S_DM_BUSY = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_streak;
  logic [7:0]  r_wdog;
  logic        r_mem_req;
  logic        r_mem_wr;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wmask;
  logic [31:0] r_if_data;
  logic [31:0] r_dm_data;
  logic        r_if_ack;
  logic        r_dm_ack;
  logic        r_err;

  logic        w_dm_grant;
  logic [8:0]  w_wdog_next;
  logic        w_timeout;
  logic        w_is_fetch;

  // Data wins unless fetch is waiting and the data streak is exhausted.
  assign w_dm_grant  = dm_req_in && (!if_req_in || (r_streak < c_MAX_STREAK));
  assign w_wdog_next = {1'b0, r_wdog} + 9'd1;
  assign w_timeout   = c_WDOG_EN && (w_wdog_next == c_TIMEOUT);
  assign w_is_fetch  = (r_state == S_IF_BUSY);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_streak    <= 4'd0;
      r_wdog      <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wmask <= 4'd0;
      r_if_data   <= 32'd0;
      r_dm_data   <= 32'd0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dm_grant) begin
            r_mem_req   <= 1'b1;
            r_mem_wr    <= dm_wr_in;
            r_mem_addr  <= dm_addr_in;
            r_mem_wdata <= dm_wdata_in;
            r_mem_wmask <= dm_wr_in ? dm_wmask_in : 4'd0;
            r_streak    <= if_req_in ? (r_streak + 4'd1) : 4'd0;
            r_wdog      <= 8'd0;
            r_state     <= S_DM_BUSY;
          end else if (if_req_in) begin
            r_mem_req   <= 1'b1;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= if_addr_in;
            r_mem_wdata <= 32'd0;
            r_mem_wmask <= 4'd0;
            r_streak    <= 4'd0;
            r_wdog      <= 8'd0;
            r_state     <= S_IF_BUSY;
          end
        end
        S_IF_BUSY, S_DM_BUSY: begin
          if (mem_ready_in) begin
            r_mem_req <= 1'b0;
            r_state   <= S_RESP;
            if (w_is_fetch) begin
              r_if_data <= mem_data_in;
              r_if_ack  <= 1'b1;
            end else begin
              if (!r_mem_wr) r_dm_data <= mem_data_in;
              r_dm_ack <= 1'b1;
            end
          end else if (w_timeout) begin
            // Abandon the access; the requester sees an ack flagged with err.
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_RESP;
            if (w_is_fetch) begin
              r_if_data <= 32'd0;
              r_if_ack  <= 1'b1;
            end else begin
              if (!r_mem_wr) r_dm_data <= 32'd0;
              r_dm_ack <= 1'b1;
            end
          end else begin
            r_wdog <= w_wdog_next[7:0];
          end
        end
        S_RESP: begin
          r_if_ack <= 1'b0;
          r_dm_ack <= 1'b0;
          r_err    <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_out   = r_mem_req;
  assign mem_wr_out    = r_mem_wr;
  assign mem_addr_out  = r_mem_addr;
  assign mem_wdata_out = r_mem_wdata;
  assign mem_wmask_out = r_mem_wmask;
  assign if_data_out   = r_if_data;
  assign dm_data_out   = r_dm_data;
  assign if_ack_out    = r_if_ack;
  assign dm_ack_out    = r_dm_ack;
  assign err_out       = r_err;
  assign stall_out     = (if_req_in & ~r_if_ack) | (dm_req_in & ~r_dm_ack);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_unit.sv
// ============================================================================
// tb_mem_arbiter_unit
// Directed self-checking bench for mem_arbiter_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_data;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [31:0] dm_addr = 32'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic [3:0]  dm_wmask = 4'd0;
  logic [31:0] dm_data;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_data = 32'd0;
  logic        mem_ready = 1'b0;
  logic        stall;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter_unit #(.MAX_DM_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_in(clk), .rst_in(rst),
    .if_req_in(if_req), .if_addr_in(if_addr), .if_data_out(if_data), .if_ack_out(if_ack),
    .dm_req_in(dm_req), .dm_wr_in(dm_wr), .dm_addr_in(dm_addr), .dm_wdata_in(dm_wdata),
    .dm_wmask_in(dm_wmask), .dm_data_out(dm_data), .dm_ack_out(dm_ack),
    .mem_req_out(mem_req), .mem_wr_out(mem_wr), .mem_addr_out(mem_addr),
    .mem_wdata_out(mem_wdata), .mem_wmask_out(mem_wmask), .mem_data_in(mem_data),
    .mem_ready_in(mem_ready), .stall_out(stall), .err_out(err)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_checks++; if ({if_ack, dm_ack, err} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b expected 000", {if_ack, dm_ack, err}); end
    n_checks++; if ({if_data, dm_data, mem_addr} !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {if_data, dm_data, mem_addr}); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch_zero_wait();
    if_req = 1'b1; if_addr = 32'h0000_0100; mem_ready = 1'b1; mem_data = 32'h0000_0013;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_req: got %b expected 1", stall); end
    @(negedge clk);
    n_checks++; if ({mem_req, mem_wr} !== 2'b10) begin n_fail++; $display("FAIL fetch_busy_req_wr: got %b expected 10", {mem_req, mem_wr}); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_addr: got %h expected 00000100", mem_addr); end
    n_checks++; if ({if_ack, stall} !== 2'b01) begin n_fail++; $display("FAIL fetch_busy_ack_stall: got %b expected 01", {if_ack, stall}); end
    @(negedge clk);
    n_checks++; if ({if_ack, mem_req, stall} !== 3'b100) begin n_fail++; $display("FAIL fetch_resp_ack_req_stall: got %b expected 100", {if_ack, mem_req, stall}); end
    n_checks++; if (if_data !== 32'h13) begin n_fail++; $display("FAIL fetch_data: got %h expected 00000013", if_data); end
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_checks++; if ({if_ack, if_data} !== {1'b0, 32'h13}) begin n_fail++; $display("FAIL fetch_hold: got %h expected 000000013", {if_ack, if_data}); end
  endtask

  task automatic test_load_zero_wait();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h1000; dm_wmask = 4'hF; dm_wdata = 32'h1111_2222;
    mem_ready = 1'b1; mem_data = 32'hCAFE_F00D;
    @(negedge clk);
    n_checks++; if ({mem_req, mem_wr, mem_wmask} !== 6'b100000) begin n_fail++; $display("FAIL load_busy_req_wr_mask: got %b expected 100000", {mem_req, mem_wr, mem_wmask}); end
    @(negedge clk);
    n_checks++; if ({dm_ack, dm_data} !== {1'b1, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL load_resp: got %h expected 1cafef00d", {dm_ack, dm_data}); end
    dm_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_wait2();
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF; dm_wmask = 4'b0011;
    mem_ready = 1'b0; mem_data = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({mem_req, mem_wr, mem_wmask, dm_ack} !== 7'b1100110) begin n_fail++; $display("FAIL store_busy_%0d: got %b expected 1100110", i, {mem_req, mem_wr, mem_wmask, dm_ack}); end
      n_checks++; if ({mem_addr, mem_wdata} !== {32'h2004, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL store_addr_data_%0d: got %h expected 00002004deadbeef", i, {mem_addr, mem_wdata}); end
      if (i == 2) mem_ready = 1'b1;
    end
    @(negedge clk);
    n_checks++; if ({dm_ack, mem_req, err} !== 3'b100) begin n_fail++; $display("FAIL store_resp: got %b expected 100", {dm_ack, mem_req, err}); end
    n_checks++; if (dm_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL store_dm_data: got %h expected cafef00d", dm_data); end
    dm_req = 1'b0; dm_wr = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (dm_ack !== 1'b0) begin n_fail++; $display("FAIL store_ack_pulse: got %b expected 0", dm_ack); end
  endtask

  task automatic test_streak();
    logic got [6];
    logic exp [6];
    int   n;
    exp[0] = 1'b0; exp[1] = 1'b0; exp[2] = 1'b0; exp[3] = 1'b0; exp[4] = 1'b1; exp[5] = 1'b0;
    n = 0;
    if_req = 1'b1; if_addr = 32'h400; dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h3000;
    mem_ready = 1'b1; mem_data = 32'h55AA_55AA;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (if_ack || dm_ack) begin
        got[n] = if_ack;
        n++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    n_checks++;
    if (n != 6) begin
      n_fail++; $display("FAIL streak_timeout: got %0d acks expected 6", n);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL streak_grant_%0d: got fetch=%b expected fetch=%b", i, got[i], exp[i]); end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_watchdog();
    n_checks++; if (dm_data !== 32'h55AA_55AA) begin n_fail++; $display("FAIL wdog_pre_data: got %h expected 55aa55aa", dm_data); end
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h3000; mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++; if ({mem_req, dm_ack, err} !== 3'b100) begin n_fail++; $display("FAIL wdog_wait_%0d: got %b expected 100", i, {mem_req, dm_ack, err}); end
    end
    @(negedge clk);
    n_checks++; if ({mem_req, dm_ack, err} !== 3'b011) begin n_fail++; $display("FAIL wdog_expire: got %b expected 011", {mem_req, dm_ack, err}); end
    n_checks++; if (dm_data !== 32'd0) begin n_fail++; $display("FAIL wdog_data: got %h expected 00000000", dm_data); end
    dm_req = 1'b0;
    @(negedge clk);
    n_checks++; if ({dm_ack, err} !== 2'b00) begin n_fail++; $display("FAIL wdog_pulse: got %b expected 00", {dm_ack, err}); end
  endtask

  task automatic test_reset_mid();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h5000; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 1", mem_req); end
    rst = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    n_checks++; if ({mem_req, mem_wr, mem_addr, mem_wmask, if_ack, dm_ack, err} !== 41'd0) begin n_fail++; $display("FAIL rstmid_outputs: got %h expected 0", {mem_req, mem_wr, mem_addr, mem_wmask, if_ack, dm_ack, err}); end
    n_checks++; if ({if_data, dm_data} !== 64'd0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", {if_data, dm_data}); end
    rst = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({dm_ack, mem_req} !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_ack_%0d: got %b expected 00", i, {dm_ack, mem_req}); end
    end
    if_req = 1'b1; if_addr = 32'h200; mem_data = 32'h0000_0777;
    repeat (2) @(negedge clk);
    n_checks++; if ({if_ack, if_data} !== {1'b1, 32'h777}) begin n_fail++; $display("FAIL rstmid_refetch: got %h expected 100000777", {if_ack, if_data}); end
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_held_through_resp();
    if_req = 1'b1; if_addr = 32'h300; mem_ready = 1'b1; mem_data = 32'h99;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL held_grant1: got %b expected 1", mem_req); end
    @(negedge clk);
    n_checks++; if ({if_ack, if_data} !== {1'b1, 32'h99}) begin n_fail++; $display("FAIL held_ack1: got %h expected 100000099", {if_ack, if_data}); end
    @(negedge clk);
    n_checks++; if ({mem_req, if_ack} !== 2'b00) begin n_fail++; $display("FAIL held_no_grant_in_resp: got %b expected 00", {mem_req, if_ack}); end
    @(negedge clk);
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL held_grant2: got %h expected 100000300", {mem_req, mem_addr}); end
    @(negedge clk);
    n_checks++; if (if_ack !== 1'b1) begin n_fail++; $display("FAIL held_ack2: got %b expected 1", if_ack); end
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_load_zero_wait();
    test_store_wait2();
    test_streak();
    test_watchdog();
    test_reset_mid();
    test_held_through_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
